// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clock divider run/stop controller.
package clk_div_pkg;

  localparam int CNT_W_DEFAULT    = 8;
  localparam int DEF_HALF_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Configuration handshake between the config logic and the divider controller.
interface clk_div_cfg_if #(
  parameter int CNT_W = 8
) ();

  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_half,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_half,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_core.sv
// Half-period counter plus toggle flop. Counts only while run is high and
// otherwise parks with cnt=0, clk_out=0. restart clears synchronously.
module clk_div_core #(
  parameter int CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  input  logic             restart,
  output logic             clk_out,
  output logic             period_end,
  output logic             rise
);

  logic [CNT_W-1:0] cnt_r;
  logic             clk_r;
  logic             term_s;

  // Terminal count detect and the falling/rising toggle qualifiers.
  always_comb begin
    term_s     = (cnt_r == (half - CNT_W'(1)));
    period_end = run & term_s & clk_r;
    rise       = run & term_s & ~clk_r;
  end

  // Counter and toggle flop; a wrap always lands on 0 so a new half value
  // takes effect from a clean phase start.
  always_ff @(posedge sys_clk) begin
    if (restart) begin
      cnt_r <= {CNT_W{1'b0}};
      clk_r <= 1'b0;
    end else if (!run) begin
      cnt_r <= {CNT_W{1'b0}};
      clk_r <= 1'b0;
    end else if (term_s) begin
      cnt_r <= {CNT_W{1'b0}};
      clk_r <= ~clk_r;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      clk_r <= clk_r;
    end
  end

  assign clk_out = clk_r;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop controller for the 50%-duty even clock divider. New half-period
// settings are applied only at full-period boundaries (the falling toggle),
// and clk_out always parks low when stopped.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int DEF_HALF = DEF_HALF_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  clk_div_cfg_if.slave     cfg,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
);

  state_e           state_r;
  state_e           state_s;
  logic [CNT_W-1:0] half_r;
  logic [CNT_W-1:0] half_s;
  logic [CNT_W-1:0] pend_half_r;
  logic [CNT_W-1:0] pend_half_s;
  logic             pend_vld_r;
  logic             pend_vld_s;
  logic             cfg_ready_r;
  logic             cfg_err_r;
  logic             rise_tick_r;
  logic             busy_r;

  logic             accept_s;
  logic             accept_zero_s;
  logic             accept_live_s;
  logic             period_end_s;
  logic             rise_s;
  logic             run_s;

  assign run_s = (state_r != IDLE);

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .sys_clk    (sys_clk),
    .run        (run_s),
    .half       (half_r),
    .restart    (sys_rst),
    .clk_out    (clk_out),
    .period_end (period_end_s),
    .rise       (rise_s)
  );

  // Next-state logic: stopping is only allowed at a period end so the
  // high phase always completes.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          if (period_end_s) begin
            state_s = IDLE;
          end else begin
            state_s = DRAIN;
          end
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (en) begin
          state_s = RUN;
        end else if (period_end_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Config handshake: zero is consumed and flagged, nonzero goes straight in
  // while idle or waits in the pending slot until the next period end.
  always_comb begin
    half_s        = half_r;
    pend_half_s   = pend_half_r;
    pend_vld_s    = pend_vld_r;
    accept_s      = cfg.cfg_valid & cfg_ready_r;
    accept_zero_s = accept_s & (cfg.cfg_half == {CNT_W{1'b0}});
    accept_live_s = accept_s & (cfg.cfg_half != {CNT_W{1'b0}});
    if (period_end_s && pend_vld_r) begin
      half_s     = pend_half_r;
      pend_vld_s = 1'b0;
    end else begin
      pend_vld_s = pend_vld_r;
    end
    // A pending slot is never full when accepting, so this cannot collide
    // with the apply above.
    if (accept_live_s) begin
      if (state_r == IDLE) begin
        half_s = cfg.cfg_half;
      end else begin
        pend_half_s = cfg.cfg_half;
        pend_vld_s  = 1'b1;
      end
    end else begin
      pend_half_s = pend_half_s;
    end
  end

  // State, settings and registered status outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= IDLE;
      half_r      <= CNT_W'(DEF_HALF);
      pend_half_r <= {CNT_W{1'b0}};
      pend_vld_r  <= 1'b0;
      cfg_ready_r <= 1'b1;
      cfg_err_r   <= 1'b0;
      rise_tick_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      half_r      <= half_s;
      pend_half_r <= pend_half_s;
      pend_vld_r  <= pend_vld_s;
      cfg_ready_r <= ~pend_vld_s;
      cfg_err_r   <= accept_zero_s;
      rise_tick_r <= rise_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  assign cfg.cfg_ready = cfg_ready_r;
  assign cfg.cfg_err   = cfg_err_r;
  assign rise_tick     = rise_tick_r;
  assign busy          = busy_r;
  assign cur_half      = half_r;

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run/stop controller for the team's 50%-duty even clock divider.
- Holds the half-period setting and accepts new settings through a valid/ready handshake.
- Applies new settings only at full-period boundaries, so clk_out never glitches or produces a runt phase.
- Starts and stops cleanly: clk_out always parks low. Sits between the configuration logic and every divided-clock consumer.

Parameters:
- CNT_W, 8: width of the half-period counter and the setting.
- DEF_HALF, 3: half-period applied at reset. 3 gives divide-by-6.

Ports:
- sys_clk  in  1: system clock.
- sys_rst  in  1: reset, synchronous, active-high.
- en  in  1: level request to run the divider.
- cfg_valid  in  1: new half-period offered.
- cfg_half  in  CNT_W: offered half-period, in sys_clk cycles.
- cfg_ready  out  1: controller can accept a setting.
- cfg_err  out  1: one-cycle pulse; a zero setting was rejected.
- clk_out  out  1: divided clock, registered.
- rise_tick  out  1: one-cycle pulse, high in the cycle clk_out first reads 1.
- busy  out  1: high while in RUN or DRAIN.
- cur_half  out  CNT_W: half-period currently in effect.

Behaviour:
- Reset values: state=IDLE, cnt=0, clk_out=0, half_reg=DEF_HALF, pend_vld=0, cfg_err=0, rise_tick=0, busy=0, cfg_ready=1. Pending settings are discarded.
- Reset applied mid-operation returns everything to these values on the next edge. clk_out may be cut short; that is acceptable.
- Output period is 2*half_reg sys_clk cycles at 50% duty. half_reg=1 gives divide-by-2.
- States and transitions:
  - IDLE: cnt=0, clk_out=0. Goes to RUN when en=1.
  - RUN: each cycle, if cnt==half_reg-1 then cnt<=0 and clk_out<=~clk_out; otherwise cnt<=cnt+1. Goes to DRAIN when en=0.
  - DRAIN: counts exactly as RUN. Returns to RUN when en=1, with no disturbance to clk_out or cnt. Goes to IDLE at the next period end.
- Period end: the cycle in which cnt==half_reg-1 and clk_out==1, i.e. the falling toggle.
- First rising edge of clk_out: the half_reg-th edge after RUN is entered. Example: DEF_HALF=3, en high from reset release gives clk_out=1 four edges after sys_rst drops.
- Config accept condition: cfg_valid && cfg_ready. cfg_ready = ~pend_vld.
- Accepting cfg_half==0: the value is consumed, nothing changes, and cfg_err=1 on the next cycle.
- Accepting a nonzero setting in IDLE: half_reg is updated on the next edge.
- Accepting a nonzero setting in RUN or DRAIN: pend_half/pend_vld are loaded and cfg_ready goes low.
  - At the next period end, half_reg<=pend_half and pend_vld<=0.
  - The counter restarts at 0 under the new value.
- Simultaneous events:
  - A setting accepted in the same cycle as a period end applies at the following period end.
  - If a pending setting exists when DRAIN reaches IDLE, it is applied on that same edge.
  - If en falls and a period end occurs in the same cycle, the state goes straight to IDLE.
- busy is registered from the next state. cur_half = half_reg.

Decomposition:
- Package clk_div_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, 2 bits);
  - DEF_HALF_DEFAULT=3;
  - CNT_W_DEFAULT=8.
- Sub-module clk_div_core (one instance): loadable counter plus toggle flop.
  - Inputs: run, half, restart.
  - Outputs: clk_out, period_end, rise.
- FSM and config handshake live in the top level.

Test Plan:
- Reset release with en=1 held and no config → clk_out toggles every 3 cycles (period 6); rise_tick pulses once per 6 cycles; cur_half=3, busy=1.
- In IDLE, cfg_half=5 → cfg_ready=1 and the value is accepted; then en=1 → period 10; cur_half=5 one cycle after accept.
- While running with half=3, accept cfg_half=1 mid-high-phase → cfg_ready=0 until the next falling toggle; the old high phase completes at full length (3); then period is 2; no phase shorter than 1 or longer than 3.
- cfg_half=0 offered → cfg_err pulses for exactly one cycle one cycle later; half_reg is unchanged; cfg_ready stays 1.
- en dropped one cycle after a rising edge (half=3) → DRAIN; clk_out completes its high phase; IDLE with clk_out=0 and busy=0 at the period end. A variant re-asserts en during DRAIN: continuous period-6 output with no gap.
- sys_rst pulsed for 1 cycle while running with half=5 and a pending 2 → next cycle: clk_out=0, cur_half=3, cfg_ready=1, busy=0, and the pending value is lost.
